// File: rtl/wb_stage_if.sv
// Writeback stage bus: instruction handshake from upstream, cache return,
// and the registered triple presented to the register file.
interface wb_stage_if;
    logic        valid_in;
    logic        ready_out;
    logic        is_load;
    logic        reg_write_in;
    logic [4:0]  rd_in;
    logic [63:0] alu_result;
    logic [2:0]  funct3;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic [4:0]  rd;
    logic [63:0] writedata;
    logic        reg_write;
    logic        busy;
    logic        mem_timeout;

    modport master (
        output valid_in, is_load, reg_write_in, rd_in, alu_result, funct3,
               mem_rdata, mem_ready,
        input  ready_out, rd, writedata, reg_write, busy, mem_timeout
    );

    modport slave (
        input  valid_in, is_load, reg_write_in, rd_in, alu_result, funct3,
               mem_rdata, mem_ready,
        output ready_out, rd, writedata, reg_write, busy, mem_timeout
    );
endinterface

// File: rtl/wb_stage.sv
// RV64 writeback stage: ALU results and loads (with cache wait and timeout)
// into a registered rd/writedata/reg_write triple; x0 is never written.
module wb_stage #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       reset,
    wb_stage_if.slave  bus
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    typedef struct packed {
        logic [4:0] rd;
        logic       we;
        logic [2:0] f3;
        logic [2:0] off;
    } pend_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt;
    pend_t         pend;
    logic          timeout_hit;

    function automatic logic [63:0] extract(input logic [2:0] f3, input logic [2:0] off,
                                            input logic [63:0] d);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] w;
        b = d[8*off +: 8];
        h = d[16*off[2:1] +: 16];
        w = d[32*off[2] +: 32];
        case (f3[1:0])
            2'b00:   extract = f3[2] ? {56'b0, b} : {{56{b[7]}}, b};
            2'b01:   extract = f3[2] ? {48'b0, h} : {{48{h[15]}}, h};
            2'b10:   extract = f3[2] ? {32'b0, w} : {{32{w[31]}}, w};
            default: extract = d;
        endcase
    endfunction

    // mem_ready on the last allowed cycle still completes the load
    assign timeout_hit = (state == WAIT_MEM) && !bus.mem_ready &&
                         (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (bus.valid_in && bus.is_load && !bus.mem_ready) state_nxt = WAIT_MEM;
            WAIT_MEM: if (bus.mem_ready || timeout_hit) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        bus.ready_out = (state == IDLE);
        bus.busy      = (state == WAIT_MEM);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.rd          <= '0;
            bus.writedata   <= '0;
            bus.reg_write   <= 1'b0;
            bus.mem_timeout <= 1'b0;
            cnt             <= '0;
            pend            <= '0;
        end else begin
            bus.reg_write <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.valid_in) begin
                        if (!bus.is_load || bus.mem_ready) begin
                            bus.rd        <= bus.rd_in;
                            bus.writedata <= bus.is_load ?
                                extract(bus.funct3, bus.alu_result[2:0], bus.mem_rdata) :
                                bus.alu_result;
                            bus.reg_write <= bus.reg_write_in && (bus.rd_in != 5'd0);
                        end else begin
                            // write filter is folded in at latch time
                            pend.rd  <= bus.rd_in;
                            pend.we  <= bus.reg_write_in && (bus.rd_in != 5'd0);
                            pend.f3  <= bus.funct3;
                            pend.off <= bus.alu_result[2:0];
                            cnt      <= '0;
                        end
                    end
                end
                WAIT_MEM: begin
                    if (bus.mem_ready) begin
                        bus.rd        <= pend.rd;
                        bus.writedata <= extract(pend.f3, pend.off, bus.mem_rdata);
                        bus.reg_write <= pend.we;
                    end else if (timeout_hit) begin
                        bus.mem_timeout <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed vector table, corner sequences and random
// transactions against a transaction-level model, on two timeout settings.
module tb_wb_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wb_stage_if i64 ();
    wb_stage_if i4 ();

    logic        sel, v, ld, rwi, mrdy;
    logic [4:0]  rdi;
    logic [63:0] alu, mrd;
    logic [2:0]  f3;

    assign i64.valid_in = v & ~sel;     assign i4.valid_in = v & sel;
    assign i64.mem_ready = mrdy & ~sel; assign i4.mem_ready = mrdy & sel;
    assign i64.is_load = ld;       assign i4.is_load = ld;
    assign i64.reg_write_in = rwi; assign i4.reg_write_in = rwi;
    assign i64.rd_in = rdi;        assign i4.rd_in = rdi;
    assign i64.alu_result = alu;   assign i4.alu_result = alu;
    assign i64.funct3 = f3;        assign i4.funct3 = f3;
    assign i64.mem_rdata = mrd;    assign i4.mem_rdata = mrd;

    wb_stage #(.TIMEOUT_CYCLES(64)) dut64 (.clk(clk), .reset(rst), .bus(i64));
    wb_stage #(.TIMEOUT_CYCLES(4))  dut4  (.clk(clk), .reset(rst), .bus(i4));

    logic [4:0]  o_rd;
    logic [63:0] o_wd;
    logic        o_we, o_busy, o_ready, o_to;
    assign o_rd    = sel ? i4.rd          : i64.rd;
    assign o_wd    = sel ? i4.writedata   : i64.writedata;
    assign o_we    = sel ? i4.reg_write   : i64.reg_write;
    assign o_busy  = sel ? i4.busy        : i64.busy;
    assign o_ready = sel ? i4.ready_out   : i64.ready_out;
    assign o_to    = sel ? i4.mem_timeout : i64.mem_timeout;

    typedef struct {
        logic        ld;
        logic        rwi;
        logic [4:0]  rd;
        logic [63:0] alu;
        logic [2:0]  f3;
        logic [63:0] rdata;
        int          lat;
        logic [63:0] exp_wd;
        logic        exp_we;
    } txn_t;

    int errors = 0;
    int checks = 0;
    logic [4:0]  exp_rd [2];
    logic [63:0] exp_wd [2];
    logic        exp_to [2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Load result from the RISC-V rules: access size, size-aligned offset, extension.
    function automatic logic [63:0] mext(input logic [2:0] fn, input logic [2:0] off,
                                         input logic [63:0] d);
        int sz, b;
        logic [63:0] r, mask;
        sz = 1 << fn[1:0];
        b  = (int'(off) / sz) * sz;
        r  = d >> (8 * b);
        if (sz < 8) begin
            mask = (64'd1 << (8 * sz)) - 64'd1;
            r = r & mask;
            if (!fn[2] && r[8*sz-1]) r = r | ~mask;
        end
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            exp_rd[i] = '0; exp_wd[i] = '0; exp_to[i] = 1'b0;
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_rd"}, 64'(o_rd), 64'(exp_rd[sel]));
        chk({tag, "_wd"}, o_wd, exp_wd[sel]);
        chk({tag, "_to"}, 64'(o_to), 64'(exp_to[sel]));
        chk({tag, "_busy"}, 64'(o_busy), 64'd0);
        chk({tag, "_ready"}, 64'(o_ready), 64'd1);
    endtask

    task automatic run_txn(input txn_t t, input logic s);
        int tmo, nw;
        logic wr;
        tmo = s ? 4 : 64;
        wr  = !t.ld || (t.lat == 0) || (t.lat <= tmo);
        sel = s;
        for (int i = 0; i < 10 && !o_ready; i++) step();
        chk("ready_wait", 64'(o_ready), 64'd1);
        v = 1'b1; ld = t.ld; rwi = t.rwi; rdi = t.rd; alu = t.alu; f3 = t.f3;
        mrdy = t.ld && (t.lat == 0);
        mrd  = mrdy ? t.rdata : {$urandom, $urandom};
        step();
        if (t.ld && t.lat > 0) begin
            nw = wr ? t.lat : tmo;
            for (int w = 1; w <= nw; w++) begin
                chk("wait_busy", 64'(o_busy), 64'd1);
                chk("wait_ready", 64'(o_ready), 64'd0);
                chk("wait_we", 64'(o_we), 64'd0);
                // instruction fields must come from the latch, not the live bus
                rwi = 1'($urandom); rdi = 5'($urandom); alu = {$urandom, $urandom};
                f3 = 3'($urandom); ld = 1'($urandom);
                mrdy = (w == t.lat);
                mrd  = mrdy ? t.rdata : {$urandom, $urandom};
                step();
            end
        end
        v = 1'b0; mrdy = 1'b0;
        if (wr) begin
            exp_rd[s] = t.rd; exp_wd[s] = t.exp_wd;
        end else begin
            exp_to[s] = 1'b1;
        end
        chk("done_we", 64'(o_we), 64'(wr && t.exp_we));
        chk_all("done");
        step();
        chk("pulse_end_we", 64'(o_we), 64'd0);
        chk("hold_wd", o_wd, exp_wd[s]);
    endtask

    txn_t tbl [13];
    txn_t t;

    initial begin
        v = 0; ld = 0; rwi = 0; rdi = 0; alu = 0; f3 = 0; mrd = 0; mrdy = 0; sel = 0;
        model_reset();
        step(); step();
        rst = 1'b0;
        for (int s = 0; s < 2; s++) begin
            sel = 1'(s);
            #1;
            chk("rst_we", 64'(o_we), 64'd0);
            chk_all("rst");
        end

        tbl[0]  = '{0, 1, 5,  64'h1234, 3'b000, 64'h0, 0, 64'h1234, 1};
        tbl[1]  = '{0, 1, 0,  64'hABCD, 3'b000, 64'h0, 0, 64'hABCD, 0};
        tbl[2]  = '{1, 1, 9,  64'h3, 3'b000, 64'h80FF0000, 0, 64'hFFFF_FFFF_FFFF_FF80, 1};
        tbl[3]  = '{1, 1, 9,  64'h3, 3'b100, 64'h80FF0000, 0, 64'h80, 1};
        tbl[4]  = '{1, 1, 12, 64'h1004, 3'b010, 64'h8000_0001_0000_0000, 5, 64'hFFFF_FFFF_8000_0001, 1};
        tbl[5]  = '{1, 1, 12, 64'h1004, 3'b110, 64'h8000_0001_0000_0000, 5, 64'h8000_0001, 1};
        tbl[6]  = '{1, 1, 3,  64'h3, 3'b001, 64'h80FF0000, 0, 64'hFFFF_FFFF_FFFF_80FF, 1};
        tbl[7]  = '{1, 1, 4,  64'h6, 3'b101, 64'h1234_5678_9ABC_DEF0, 2, 64'h1234, 1};
        tbl[8]  = '{1, 1, 31, 64'h5, 3'b011, 64'hDEAD_BEEF_CAFE_F00D, 0, 64'hDEAD_BEEF_CAFE_F00D, 1};
        tbl[9]  = '{1, 1, 30, 64'h2, 3'b111, 64'h0123_4567_89AB_CDEF, 3, 64'h0123_4567_89AB_CDEF, 1};
        tbl[10] = '{0, 0, 7,  64'h5555, 3'b000, 64'h0, 0, 64'h5555, 0};
        tbl[11] = '{1, 1, 2,  64'h7, 3'b000, 64'hFE00_0000_0000_0000, 1, 64'hFFFF_FFFF_FFFF_FFFE, 1};
        tbl[12] = '{1, 0, 8,  64'h0, 3'b011, 64'h1111, 2, 64'h1111, 0};
        for (int i = 0; i < 13; i++) run_txn(tbl[i], 1'b0);

        // mem_ready on the final timeout cycle wins, then a real timeout
        run_txn('{1, 1, 6, 64'h0, 3'b011, 64'hCAFE, 4, 64'hCAFE, 1}, 1'b1);
        run_txn('{1, 1, 6, 64'h0, 3'b011, 64'hBEEF, 100, 64'h0, 0}, 1'b1);
        run_txn('{0, 1, 1, 64'h77, 3'b000, 64'h0, 0, 64'h77, 1}, 1'b1);

        // reset while waiting abandons the load
        sel = 0; v = 1; ld = 1; rwi = 1; rdi = 5; f3 = 3'b011; alu = 0; mrdy = 0;
        step();
        v = 0;
        step();
        chk("midrst_busy", 64'(o_busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0; mrdy = 1'b1; mrd = 64'h9999;
        step();
        mrdy = 1'b0;
        model_reset();
        chk("midrst_we", 64'(o_we), 64'd0);
        chk_all("midrst");
        step();
        chk("midrst_we2", 64'(o_we), 64'd0);
        sel = 1; #1;
        chk("midrst_to4", 64'(o_to), 64'd0);

        for (int n = 0; n < 60; n++) begin
            logic s;
            s = 1'($urandom);
            t.ld = 1'($urandom); t.rwi = 1'($urandom_range(0, 3) != 0);
            t.rd = 5'($urandom_range(0, 31)); t.alu = {$urandom, $urandom};
            t.f3 = 3'($urandom); t.rdata = {$urandom, $urandom};
            t.lat = t.ld ? (s ? int'($urandom_range(0, 6)) : int'($urandom_range(0, 8))) : 0;
            t.exp_wd = t.ld ? mext(t.f3, t.alu[2:0], t.rdata) : t.alu;
            t.exp_we = t.rwi && (t.rd != 0);
            run_txn(t, s);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
